// File: rtl/cvxif_mac_issuer.sv
// CV-X-IF initiator that streams packed-int8 MAC instructions to the coprocessor
// and returns the accumulated result of each job on a valid/ready handshake.
package cvxif_mac_pkg;
    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned X_NUM_RS    = 2;
    localparam int unsigned X_RFR_WIDTH = 32;

    typedef struct packed {
        logic [15:0]           instr;
        logic [1:0]            mode;
        logic [X_ID_WIDTH-1:0] id;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]                             instr;
        logic [1:0]                              mode;
        logic [X_ID_WIDTH-1:0]                   id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]    rs;
        logic [X_NUM_RS-1:0]                     rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           addr;
        logic [1:0]            mode;
        logic                  we;
        logic [1:0]            size;
        logic [31:0]           wdata;
        logic                  last;
        logic                  spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           rdata;
        logic                  err;
        logic                  dbg;
    } x_mem_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    typedef struct packed {
        logic              x_compressed_valid;
        x_compressed_req_t x_compressed_req;
        logic              x_issue_valid;
        x_issue_req_t      x_issue_req;
        logic              x_commit_valid;
        x_commit_t         x_commit;
        logic              x_mem_ready;
        x_mem_resp_t       x_mem_resp;
        logic              x_mem_result_valid;
        x_mem_result_t     x_mem_result;
        logic              x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic               x_compressed_ready;
        x_compressed_resp_t x_compressed_resp;
        logic               x_issue_ready;
        x_issue_resp_t      x_issue_resp;
        logic               x_mem_valid;
        x_mem_req_t         x_mem_req;
        logic               x_result_valid;
        x_result_t          x_result;
    } cvxif_resp_t;
endpackage

module cvxif_mac_issuer
    import cvxif_mac_pkg::*;
#(
    parameter int unsigned LenWidth      = 16,
    parameter logic [4:0]  RdIdx         = 5'd10,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [LenWidth-1:0] cmd_len_i,
    input  logic                cmd_keep_i,
    input  logic                op_valid_i,
    output logic                op_ready_o,
    input  logic [31:0]         op_a_i,
    input  logic [31:0]         op_b_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [31:0]         res_data_o,
    output logic                res_err_o,
    output cvxif_req_t          cvxif_req_o,
    input  cvxif_resp_t         cvxif_resp_i
);

    localparam logic [6:0]  OpMac    = 7'b0101011;
    localparam logic [6:0]  OpRd     = 7'b1011011;
    localparam int unsigned TmoWidth = $clog2(TimeoutCycles + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_OP,
        S_ISSUE,
        S_COMMIT,
        S_WAIT_RES,
        S_ISSUE_RD,
        S_COMMIT_RD,
        S_WAIT_RD,
        S_KILL,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state, state_next;
    logic [LenWidth-1:0]   len_cnt;
    logic                  keep;
    logic [31:0]           op_a, op_b, res_data;
    logic [X_ID_WIDTH-1:0] id_cnt, issued_id;
    logic [TmoWidth-1:0]   tmo_cnt;

    logic issuing, waiting, issue_fire, result_match, tmo_hit;

    assign issuing      = (state == S_ISSUE) || (state == S_ISSUE_RD);
    assign waiting      = (state == S_WAIT_RES) || (state == S_WAIT_RD);
    assign issue_fire   = issuing && cvxif_resp_i.x_issue_ready;
    assign result_match = waiting && cvxif_resp_i.x_result_valid
                          && (cvxif_resp_i.x_result.id == issued_id);
    assign tmo_hit      = (issuing || waiting) && (tmo_cnt == TmoWidth'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            len_cnt   <= '0;
            keep      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            res_data  <= '0;
            id_cnt    <= '0;
            issued_id <= '0;
            tmo_cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                tmo_cnt <= '0;
            end else if (issuing || waiting) begin
                tmo_cnt <= tmo_cnt + TmoWidth'(1);
            end
            if (state == S_IDLE && cmd_valid_i) begin
                len_cnt <= cmd_len_i;
                keep    <= cmd_keep_i;
            end
            if (state == S_WAIT_OP && op_valid_i) begin
                op_a <= op_a_i;
                op_b <= op_b_i;
            end
            if (issue_fire) begin
                issued_id <= id_cnt;
            end
            // Killed instructions do not consume an id; only real commits advance it.
            if (state == S_COMMIT || state == S_COMMIT_RD) begin
                id_cnt <= id_cnt + X_ID_WIDTH'(1);
            end
            if (state == S_WAIT_RES && result_match) begin
                len_cnt <= len_cnt - LenWidth'(1);
            end
            if (state == S_WAIT_RD && result_match) begin
                res_data <= cvxif_resp_i.x_result.data;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_next = (cmd_len_i != '0) ? S_WAIT_OP : S_ISSUE_RD;
                end
            end
            S_WAIT_OP: begin
                if (op_valid_i) state_next = S_ISSUE;
            end
            S_ISSUE, S_ISSUE_RD: begin
                if (issue_fire) begin
                    if (!cvxif_resp_i.x_issue_resp.accept) begin
                        state_next = S_KILL;
                    end else begin
                        state_next = (state == S_ISSUE) ? S_COMMIT : S_COMMIT_RD;
                    end
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_COMMIT:    state_next = S_WAIT_RES;
            S_COMMIT_RD: state_next = S_WAIT_RD;
            S_WAIT_RES: begin
                if (result_match) begin
                    state_next = (len_cnt == LenWidth'(1)) ? S_ISSUE_RD : S_WAIT_OP;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_WAIT_RD: begin
                if (result_match) begin
                    state_next = S_DONE;
                end else if (tmo_hit) begin
                    state_next = S_ERR;
                end
            end
            S_KILL: state_next = S_ERR;
            S_DONE, S_ERR: begin
                if (res_ready_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cvxif_req_o               = '0;
        cvxif_req_o.x_issue_valid = issuing;
        if (issuing) begin
            cvxif_req_o.x_issue_req.instr = {7'b0, 5'd2, 5'd1, 3'b000,
                                             (state == S_ISSUE_RD) ? RdIdx : 5'd0,
                                             (state == S_ISSUE_RD) ? OpRd : OpMac};
            cvxif_req_o.x_issue_req.mode     = 2'b11;
            cvxif_req_o.x_issue_req.id       = id_cnt;
            cvxif_req_o.x_issue_req.rs_valid = '1;
            cvxif_req_o.x_issue_req.rs[0]    = (state == S_ISSUE) ? op_a : {31'b0, keep};
            cvxif_req_o.x_issue_req.rs[1]    = (state == S_ISSUE) ? op_b : '0;
        end
        // A rejected issue is still closed out with a kill-commit before the error result.
        cvxif_req_o.x_commit_valid = (state == S_COMMIT) || (state == S_COMMIT_RD) || (state == S_KILL);
        if (cvxif_req_o.x_commit_valid) begin
            cvxif_req_o.x_commit.id          = issued_id;
            cvxif_req_o.x_commit.commit_kill = (state == S_KILL);
        end
        cvxif_req_o.x_result_ready = waiting;
    end

    assign cmd_ready_o = (state == S_IDLE);
    assign op_ready_o  = (state == S_WAIT_OP);
    assign res_valid_o = (state == S_DONE) || (state == S_ERR);
    assign res_err_o   = (state == S_ERR);
    assign res_data_o  = (state == S_DONE) ? res_data : '0;

    logic unused_resp;
    assign unused_resp = ^cvxif_resp_i;

endmodule

// File: tb/tb_cvxif_mac_issuer.sv
// Scoreboard bench: a stand-in MAC coprocessor answers the CV-X-IF requests while a
// reference model predicts every issue, commit and job result.
module tb_cvxif_mac_issuer;
    import cvxif_mac_pkg::*;

    localparam int unsigned TMO     = 255;
    localparam logic [6:0]  OPC_MAC = 7'b0101011;
    localparam logic [6:0]  OPC_RD  = 7'b1011011;
    localparam logic [31:0] MAC_INSTR = {7'b0, 5'd2, 5'd1, 3'b000, 5'd0, OPC_MAC};
    localparam logic [31:0] RD_INSTR  = {7'b0, 5'd2, 5'd1, 3'b000, 5'd10, OPC_RD};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_keep = 1'b0;
    logic [15:0] cmd_len = '0;
    logic        op_valid = 1'b0, op_ready;
    logic [31:0] op_a = '0, op_b = '0;
    logic        res_valid, res_ready = 1'b0, res_err;
    logic [31:0] res_data;
    cvxif_req_t  cvxif_req;
    cvxif_resp_t cvxif_resp;

    cvxif_mac_issuer #(.LenWidth(16), .RdIdx(5'd10), .TimeoutCycles(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len), .cmd_keep_i(cmd_keep),
        .op_valid_i(op_valid), .op_ready_o(op_ready), .op_a_i(op_a), .op_b_i(op_b),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_err_o(res_err),
        .cvxif_req_o(cvxif_req), .cvxif_resp_i(cvxif_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] instr; logic [31:0] rs0; logic [31:0] rs1; logic [3:0] id; } exp_issue_t;
    typedef struct { logic [3:0] id; logic kill; } exp_commit_t;
    typedef struct { logic [31:0] data; logic err; } exp_res_t;

    exp_issue_t  exp_issue[$];
    exp_commit_t exp_commit[$];
    exp_res_t    exp_res[$];

    int checks = 0, failures = 0, jobs_done = 0;
    int unsigned model_id = 0;
    int model_acc = 0;

    int job_reject_at = -1, job_stall_at = -1, job_issue_cnt = 0;
    bit hold_result = 1'b0, rand_rr = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ab, bb;
            ab = a[8*i +: 8];
            bb = b[8*i +: 8];
            s += int'(ab) * int'($signed(bb));
        end
        return s;
    endfunction

    // Stand-in coprocessor: accumulates committed MACs, readout returns and clears the sum.
    initial begin
        int r_acc = 0, r_delay = 0;
        bit r_pending = 1'b0;
        logic [3:0] r_id = '0;
        logic [31:0] r_data = '0, r_instr = '0, r_rs0 = '0, r_rs1 = '0;
        cvxif_resp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cvxif_resp = '0;
                r_acc = 0;
                r_pending = 1'b0;
                continue;
            end
            if (cvxif_req.x_commit_valid && !cvxif_req.x_commit.commit_kill) begin
                if (r_instr[6:0] == OPC_MAC) begin
                    r_acc += dot4(r_rs0, r_rs1);
                    r_data = r_acc;
                end else begin
                    r_data = r_acc;
                    r_acc = 0;
                end
                r_pending = 1'b1;
                r_id = cvxif_req.x_commit.id;
                r_delay = $urandom_range(0, 3);
            end
            cvxif_resp.x_result_valid = 1'b0;
            cvxif_resp.x_result = '0;
            if (r_pending && !hold_result) begin
                if (r_delay > 0) begin
                    r_delay--;
                    if ($urandom_range(0, 3) == 0) begin
                        cvxif_resp.x_result_valid = 1'b1;
                        cvxif_resp.x_result.id = r_id ^ 4'h8;
                        cvxif_resp.x_result.data = $urandom;
                    end
                end else begin
                    cvxif_resp.x_result_valid = 1'b1;
                    cvxif_resp.x_result.id = r_id;
                    cvxif_resp.x_result.data = r_data;
                    cvxif_resp.x_result.we = 1'b1;
                    if (cvxif_req.x_result_ready) r_pending = 1'b0;
                end
            end
            cvxif_resp.x_issue_ready = 1'b0;
            cvxif_resp.x_issue_resp = '0;
            if (cvxif_req.x_issue_valid && job_stall_at != job_issue_cnt && $urandom_range(0, 1) == 1) begin
                cvxif_resp.x_issue_ready = 1'b1;
                cvxif_resp.x_issue_resp.accept = (job_reject_at != job_issue_cnt);
                cvxif_resp.x_issue_resp.writeback = 1'b1;
                r_instr = cvxif_req.x_issue_req.instr;
                r_rs0 = cvxif_req.x_issue_req.rs[0];
                r_rs1 = cvxif_req.x_issue_req.rs[1];
                job_issue_cnt++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        res_ready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: pops the scoreboard whenever a handshake is about to complete.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (cvxif_req.x_issue_valid && cvxif_resp.x_issue_ready) begin
                check("issue_expected", exp_issue.size() != 0, 1);
                if (exp_issue.size() != 0) begin
                    exp_issue_t e;
                    e = exp_issue.pop_front();
                    check("issue_instr", cvxif_req.x_issue_req.instr, e.instr);
                    check("issue_id", cvxif_req.x_issue_req.id, e.id);
                    check("issue_rs0", cvxif_req.x_issue_req.rs[0], e.rs0);
                    check("issue_rs1", cvxif_req.x_issue_req.rs[1], e.rs1);
                    check("issue_mode_rsvalid", {cvxif_req.x_issue_req.mode, cvxif_req.x_issue_req.rs_valid}, 4'b1111);
                end
            end
            if (cvxif_req.x_commit_valid) begin
                check("commit_expected", exp_commit.size() != 0, 1);
                if (exp_commit.size() != 0) begin
                    exp_commit_t c;
                    c = exp_commit.pop_front();
                    check("commit_id", cvxif_req.x_commit.id, c.id);
                    check("commit_kill", cvxif_req.x_commit.commit_kill, c.kill);
                end
            end
            if (res_valid && res_ready) begin
                check("res_expected", exp_res.size() != 0, 1);
                if (exp_res.size() != 0) begin
                    exp_res_t r;
                    r = exp_res.pop_front();
                    check("res_err", res_err, r.err);
                    check("res_data", res_data, r.data);
                end
                jobs_done++;
            end
        end
    end

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic send_cmd(input int unsigned n, input bit keep);
        bit ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_len = 16'(n);
            cmd_keep = keep;
            #1;
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_accepted", ok, 1);
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input bit toggle);
        bit ok = 1'b0;
        if (toggle) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_a = a;
            op_b = b;
            #1;
            if (op_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        check("op_accepted", ok, 1);
    endtask

    task automatic run_job(input int unsigned n, input bit keep, input int reject_at, input int stall_at,
                           input bit toggle, input bit use_fixed, input logic [31:0] fa, input logic [31:0] fb);
        logic [31:0] a[$], b[$];
        int fault, lim, feed, prior, t0;
        logic [31:0] rd_data = '0;
        for (int k = 0; k < int'(n); k++) begin
            a.push_back(use_fixed ? fa : $urandom);
            b.push_back(use_fixed ? fb : $urandom);
        end
        fault = (reject_at >= 0) ? reject_at : stall_at;
        lim = (fault < 0) ? int'(n) + 1 : (reject_at >= 0 ? fault + 1 : fault);
        for (int k = 0; k < lim; k++) begin
            exp_issue_t  e;
            exp_commit_t c;
            e.id = 4'(model_id + k);
            if (k < int'(n)) begin
                e.instr = MAC_INSTR; e.rs0 = a[k]; e.rs1 = b[k];
            end else begin
                e.instr = RD_INSTR; e.rs0 = {31'b0, keep}; e.rs1 = '0;
            end
            exp_issue.push_back(e);
            c.id = e.id;
            c.kill = (reject_at >= 0 && k == fault);
            exp_commit.push_back(c);
            if (!c.kill) begin
                if (k < int'(n)) begin
                    model_acc += dot4(a[k], b[k]);
                end else begin
                    rd_data = model_acc;
                    model_acc = 0;
                end
            end
        end
        if (fault < 0) begin
            exp_res.push_back('{data: rd_data, err: 1'b0});
            model_id += n + 1;
        end else begin
            exp_res.push_back('{data: 32'd0, err: 1'b1});
            model_id += fault;
        end
        job_reject_at = reject_at;
        job_stall_at = stall_at;
        job_issue_cnt = 0;
        prior = jobs_done;
        t0 = cyc;
        send_cmd(n, keep);
        feed = (fault < 0 || fault >= int'(n)) ? int'(n) : fault + 1;
        for (int k = 0; k < feed; k++) send_op(a[k], b[k], toggle);
        @(negedge clk);
        op_valid = 1'b0;
        for (int t = 0; t < 4000 && jobs_done == prior; t++) @(negedge clk);
        check("job_completed", jobs_done > prior, 1);
        if (jobs_done == prior) finish_now();
        if (stall_at >= 0) check("timeout_latency", (cyc - t0) >= int'(TMO), 1);
        job_reject_at = -1;
        job_stall_at = -1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_op_ready", op_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_err", res_err, 0);
        check("rst_res_data", res_data, 0);
        check("rst_req_zero", |cvxif_req, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(1, 1'b0, -1, -1, 1'b0, 1'b1, 32'h04030201, 32'h01FF0102);
        run_job(3, 1'b0, -1, -1, 1'b1, 1'b1, 32'h04030201, 32'h01FF0102);
        run_job(0, 1'b0, -1, -1, 1'b0, 1'b0, '0, '0);
        run_job(3, 1'b0, 1, -1, 1'b0, 1'b0, '0, '0);
        run_job(2, 1'b0, -1, 0, 1'b0, 1'b0, '0, '0);
        run_job(2, 1'b0, -1, -1, 1'b0, 1'b0, '0, '0);
        run_job(2, 1'b1, -1, -1, 1'b0, 1'b0, '0, '0);
        run_job(1, 1'b0, -1, -1, 1'b0, 1'b0, '0, '0);
        for (int j = 0; j < 12; j++) begin
            int unsigned n;
            int rej;
            n = $urandom_range(0, 5);
            rej = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n)) : -1;
            run_job(n, 1'($urandom_range(0, 1)), rej, -1, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
        end

        // Reset while waiting for a MAC result that never comes.
        begin
            logic [31:0] a0, b0;
            bit hit = 1'b0;
            a0 = $urandom;
            b0 = $urandom;
            hold_result = 1'b1;
            rand_rr = 1'b0;
            exp_issue.push_back('{instr: MAC_INSTR, rs0: a0, rs1: b0, id: 4'(model_id)});
            exp_commit.push_back('{id: 4'(model_id), kill: 1'b0});
            send_cmd(2, 1'b0);
            send_op(a0, b0, 1'b0);
            @(negedge clk);
            op_valid = 1'b0;
            for (int t = 0; t < 200 && !hit; t++) begin
                @(negedge clk);
                #1;
                hit = cvxif_req.x_result_ready;
            end
            check("reached_wait_res", hit, 1);
            rst_n = 1'b0;
            #1;
            check("midrst_cmd_ready", cmd_ready, 1);
            check("midrst_op_ready", op_ready, 0);
            check("midrst_res_valid", res_valid, 0);
            check("midrst_res_err", res_err, 0);
            check("midrst_req_zero", |cvxif_req, 0);
            @(posedge clk);
            #1;
            check("midrst_edge_cmd_ready", cmd_ready, 1);
            check("midrst_edge_req_zero", |cvxif_req, 0);
            check("midrst_issue_q_drained", exp_issue.size(), 0);
            check("midrst_commit_q_drained", exp_commit.size(), 0);
            exp_issue.delete();
            exp_commit.delete();
            exp_res.delete();
            model_id = 0;
            model_acc = 0;
            hold_result = 1'b0;
            rand_rr = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            run_job(1, 1'b0, -1, -1, 1'b0, 1'b0, '0, '0);
        end

        repeat (5) @(negedge clk);
        finish_now();
    end

endmodule
